vc_switch_arbiter: RTL

Per-input-port arbiter that sits directly downstream of the input VC buffers and upstream of the crossbar. Each cycle it round-robins over the four VC full flags, selects one occupied VC, requests the output port encoded in that VC's flit, and waits for the crossbar grant. When granted, it launches the flit and pulses the buffer's clear strobe, which frees the VC and re-opens it to the upstream router.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/vc_switch_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router types and constants for the VC switch arbiter.
// Holds the arbiter state enum, output-port indices and the VC count.
package noc_pkg;

    localparam int NUM_VC   = 4;
    localparam int NUM_PORT = 5;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_N     = 3'd1;
    localparam logic [2:0] PORT_E     = 3'd2;
    localparam logic [2:0] PORT_S     = 3'd3;
    localparam logic [2:0] PORT_W     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        CLR  = 2'd3
    } arb_state_t;

    // Field values above PORT_W name no port and decode to an empty request.
    function automatic logic [NUM_PORT-1:0] port_onehot(input logic [2:0] field);
        port_onehot = (field <= PORT_W) ? (NUM_PORT'(1) << field) : '0;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
// The entry just after 'last' has highest priority; 'last' itself has the lowest.
module rr_pick4
    import noc_pkg::*;
(
    input  logic [NUM_VC-1:0] req,
    input  logic [1:0]        last,
    output logic              any,
    output logic [1:0]        winner
);

    logic [1:0] idx;

    // Walk from the lowest priority to the highest so the highest hit is assigned last.
    always_comb begin
        any    = 1'b0;
        winner = last;
        idx    = last;
        for (int k = NUM_VC; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/vc_switch_arbiter.sv
// vc_switch_arbiter: picks one full input VC round-robin, requests its output port
// and launches the flit on grant. Define VC_ARB_TIMEOUT_EN to add a grant-wait timeout.
module vc_switch_arbiter
    import noc_pkg::*;
#(
    parameter int flit_width = 16,
    parameter int PORT_LSB   = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EPT_FL_0,
    input  logic                  EPT_FL_1,
    input  logic                  EPT_FL_2,
    input  logic                  EPT_FL_3,
    input  logic [flit_width-1:0] read_I,
    input  logic                  port_gnt,
    output logic [1:0]            VC_NUM,
    output logic                  CLEAR,
    output logic [NUM_PORT-1:0]   port_req,
    output logic                  xbar_valid,
    output arb_state_t            dbg_state
);

    // Handshake: port_req is held in REQ until port_gnt is sampled high at an edge;
    // the flit is then valid for the crossbar (xbar_valid) for exactly the next cycle.
    arb_state_t        state_q, state_d;
    logic [1:0]        vc_num_q, vc_num_d;
    logic [1:0]        last_q, last_d;
    logic [2:0]        port_q, port_d;
    logic [2:0]        port_field;
    logic [NUM_VC-1:0] ept;
    logic [1:0]        pick_vc;
    logic              pick_any;
    logic              port_legal;
    logic              timed_out;
    logic              unused_bits;

    assign ept         = {EPT_FL_3, EPT_FL_2, EPT_FL_1, EPT_FL_0};
    assign port_field  = read_I[PORT_LSB +: 3];
    assign port_legal  = (port_field <= PORT_W);
    assign unused_bits = ^{read_I, 4'(TIMEOUT)};

    rr_pick4 u_pick (
        .req    (ept),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_vc)
    );

    always_comb begin
        state_d  = state_q;
        vc_num_d = vc_num_q;
        last_d   = last_q;
        port_d   = port_q;
        port_req = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    vc_num_d = pick_vc;
                    state_d  = REQ;
                end
            end
            REQ: begin
                port_req = port_onehot(port_field);
                port_d   = port_field;
                // An externally cleared VC is abandoned without a CLEAR strobe.
                if (!ept[vc_num_q]) begin
                    state_d = IDLE;
                end else if (!port_legal) begin
                    state_d = CLR;
                end else if (port_gnt) begin
                    state_d = SEND;
                end else if (timed_out) begin
                    last_d  = vc_num_q;
                    state_d = IDLE;
                end
            end
            SEND: begin
                port_req = port_onehot(port_q);
                state_d  = CLR;
            end
            CLR: begin
                last_d  = vc_num_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef VC_ARB_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);
    logic [3:0] cnt_q, cnt_d;

    assign timed_out = ((cnt_q + 4'd1) == TIMEOUT_CNT);

    // Counts consecutive ungranted REQ cycles; any other transition restarts it.
    always_comb begin
        cnt_d = '0;
        if (state_q == REQ && state_d == REQ) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            vc_num_q <= 2'd0;
            last_q   <= 2'd3;
            port_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            vc_num_q <= vc_num_d;
            last_q   <= last_d;
            port_q   <= port_d;
        end
    end

    assign VC_NUM     = vc_num_q;
    assign CLEAR      = (state_q == CLR);
    assign xbar_valid = (state_q == SEND);
    assign dbg_state  = state_q;

endmodule
